// File: rtl/spi_adc_responder_pkg.sv
// ============================================================================
// Module : spi_adc_pkg
// Shared types, widths, channel config codes and config decode for the
// SPI ADC responder model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_adc_pkg;

  localparam int CFG_W  = 6;
  localparam int DATA_W = 12;
  localparam int N_CH   = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_WAIT  = 2'd2,
    S_SHIFT = 2'd3
  } state_e;

  // Config word layout is {S/D, O/S, S1, S0, UNI, SLP}
  localparam logic [CFG_W-1:0] CFG_CH0 = 6'b100010;
  localparam logic [CFG_W-1:0] CFG_CH1 = 6'b110010;
  localparam logic [CFG_W-1:0] CFG_CH2 = 6'b100110;
  localparam logic [CFG_W-1:0] CFG_CH3 = 6'b110110;

  typedef struct packed {
    logic       ok;
    logic [1:0] ch;
  } ch_dec_t;

  function automatic ch_dec_t cfg_to_ch(input logic [CFG_W-1:0] cfg);
    ch_dec_t r;
    r.ok = 1'b1;
    r.ch = 2'd0;
    case (cfg)
      CFG_CH0: r.ch = 2'd0;
      CFG_CH1: r.ch = 2'd1;
      CFG_CH2: r.ch = 2'd2;
      CFG_CH3: r.ch = 2'd3;
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_adc_responder_if.sv
// ============================================================================
// Module : spi_adc_responder_if
// CONVST/SCK/SDI/SDO bus between an SPI ADC master and the responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface spi_adc_responder_if;

  logic spi_scl;
  logic spi_sdi;
  logic convst;
  logic spi_sdo;

  modport master (
    output spi_scl,
    output spi_sdi,
    output convst,
    input  spi_sdo
  );

  modport slave (
    input  spi_scl,
    input  spi_sdi,
    input  convst,
    output spi_sdo
  );

endinterface

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// Module : spi_sync_edge
// Multi-flop synchronizer with rise/fall detection on the synchronized level.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic d_i,
  output logic      lvl_o,
  output logic      rise_o,
  output logic      fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  // Edge pulses are combinational so the consumer acts one clk after detection
  assign lvl_o  = sync_q[STAGES-1];
  assign rise_o = sync_q[STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

`default_nettype wire

// File: rtl/spi_adc_responder.sv
// ============================================================================
// Module : spi_adc_responder
// LTC2308-style SPI ADC responder: config capture, timed conversion, 12-bit
// readout. Optional macro ADC_RESP_AUTOINC_EN bumps a channel per readout.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_adc_responder
  import spi_adc_pkg::*;
#(
  parameter int CONV_CYCLES = 80,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic                clk,
  input  wire logic                reset_n,
  spi_adc_responder_if.slave       spi,
  input  wire logic                wr_en,
  input  wire logic [1:0]          wr_ch,
  input  wire logic [DATA_W-1:0]   wr_data,
  output logic                     busy,
  output logic                     cfg_valid,
  output logic [CFG_W-1:0]         cfg_word,
  output logic                     cfg_err,
  output logic                     frame_err,
  output logic [15:0]              frames_done
);

  localparam int CNT_W = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(CONV_CYCLES - 1);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sdi_lvl, w_sdi_rise, w_sdi_fall;
  logic w_cv_lvl,  w_cv_rise,  w_cv_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_scl (
    .clk    (clk),
    .rst_n  (reset_n),
    .d_i    (spi.spi_scl),
    .lvl_o  (w_scl_lvl),
    .rise_o (w_scl_rise),
    .fall_o (w_scl_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk    (clk),
    .rst_n  (reset_n),
    .d_i    (spi.spi_sdi),
    .lvl_o  (w_sdi_lvl),
    .rise_o (w_sdi_rise),
    .fall_o (w_sdi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cv (
    .clk    (clk),
    .rst_n  (reset_n),
    .d_i    (spi.convst),
    .lvl_o  (w_cv_lvl),
    .rise_o (w_cv_rise),
    .fall_o (w_cv_fall)
  );

  state_e             state_q;
  logic [CNT_W-1:0]   conv_cnt_q;
  logic [DATA_W-1:0]  shift_q;
  logic [2:0]         rx_cnt_q;
  logic [3:0]         tx_cnt_q;
  logic [CFG_W-1:0]   cfg_sr_q;
  logic [CFG_W-1:0]   cfg_word_q;
  logic               sdo_q;
  logic               busy_q;
  logic               cfg_valid_q;
  logic               cfg_err_q;
  logic               frame_err_q;
  logic [15:0]        frames_done_q;
  logic [DATA_W-1:0]  value_q [N_CH];
  logic [DATA_W-1:0]  value_d [N_CH];

  ch_dec_t w_rd_dec;
  ch_dec_t w_new_dec;
  logic    w_tx_done;
  logic    w_unused;

  assign w_rd_dec  = cfg_to_ch(cfg_word_q);
  assign w_new_dec = cfg_to_ch(cfg_sr_q);

  // The 12th SCK fall completes a readout; a same-cycle convst rise pre-empts it
  assign w_tx_done = (state_q == S_SHIFT) && !w_cv_rise && w_scl_fall &&
                     (tx_cnt_q == 4'd11);

  assign w_unused = &{1'b0, w_scl_lvl, w_cv_lvl, w_sdi_rise, w_sdi_fall,
                      w_rd_dec.ok, w_new_dec.ch};

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      value_d[i] = value_q[i];
    end
`ifdef ADC_RESP_AUTOINC_EN
    if (w_tx_done) begin
      value_d[w_rd_dec.ch] = value_q[w_rd_dec.ch] + 1'b1;
    end
`endif
    if (wr_en) begin
      value_d[wr_ch] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        value_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        value_q[i] <= value_d[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      conv_cnt_q    <= '0;
      shift_q       <= '0;
      rx_cnt_q      <= '0;
      tx_cnt_q      <= '0;
      cfg_sr_q      <= '0;
      cfg_word_q    <= CFG_CH0;
      sdo_q         <= 1'b0;
      busy_q        <= 1'b0;
      cfg_valid_q   <= 1'b0;
      cfg_err_q     <= 1'b0;
      frame_err_q   <= 1'b0;
      frames_done_q <= '0;
    end else begin
      cfg_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
      frame_err_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          sdo_q  <= 1'b0;
          busy_q <= 1'b0;
          if (w_cv_rise) begin
            state_q    <= S_CONV;
            busy_q     <= 1'b1;
            conv_cnt_q <= '0;
          end
        end

        S_CONV: begin
          if (w_cv_fall) begin
            frame_err_q <= 1'b1;
            busy_q      <= 1'b0;
            sdo_q       <= 1'b0;
            state_q     <= S_IDLE;
          end else if (conv_cnt_q == CONV_LAST) begin
            busy_q  <= 1'b0;
            state_q <= S_WAIT;
          end else begin
            conv_cnt_q <= conv_cnt_q + 1'b1;
          end
        end

        S_WAIT: begin
          // Snapshot so that writes during the readout do not corrupt it
          if (w_cv_fall) begin
            shift_q  <= value_q[w_rd_dec.ch];
            sdo_q    <= value_q[w_rd_dec.ch][DATA_W-1];
            rx_cnt_q <= '0;
            tx_cnt_q <= '0;
            state_q  <= S_SHIFT;
          end
        end

        S_SHIFT: begin
          if (w_cv_rise) begin
            if ((rx_cnt_q == 3'd6) && w_new_dec.ok) begin
              cfg_word_q  <= cfg_sr_q;
              cfg_valid_q <= 1'b1;
            end else begin
              cfg_err_q <= 1'b1;
            end
            sdo_q      <= 1'b0;
            busy_q     <= 1'b1;
            conv_cnt_q <= '0;
            state_q    <= S_CONV;
          end else begin
            if (w_scl_rise && (rx_cnt_q < 3'd6)) begin
              cfg_sr_q <= {cfg_sr_q[CFG_W-2:0], w_sdi_lvl};
              rx_cnt_q <= rx_cnt_q + 1'b1;
            end
            if (w_scl_fall && (tx_cnt_q < 4'd12)) begin
              tx_cnt_q <= tx_cnt_q + 1'b1;
              shift_q  <= {shift_q[DATA_W-2:0], 1'b0};
              sdo_q    <= (tx_cnt_q < 4'd11) ? shift_q[DATA_W-2] : 1'b0;
            end
            if (w_tx_done) begin
              frames_done_q <= frames_done_q + 1'b1;
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign spi.spi_sdo = sdo_q;
  assign busy        = busy_q;
  assign cfg_valid   = cfg_valid_q;
  assign cfg_word    = cfg_word_q;
  assign cfg_err     = cfg_err_q;
  assign frame_err   = frame_err_q;
  assign frames_done = frames_done_q;

endmodule

`default_nettype wire

// File: doc/spi_adc_responder.md
Name: spi_adc_responder

Overview:
- Behavioural/synthesizable model of the LTC2308-style SPI ADC that spi_state_machine talks to.
- Acts as the responder on the CONVST/SCK/SDI/SDO interface:
  - captures the 6-bit config word from SDI;
  - runs a timed conversion;
  - shifts 12-bit channel results out on SDO.
- Channel values are loaded through a simple write port. Used in loopback benches and FPGA self-test in place of the real ADC.

Parameters:
- CONV_CYCLES, 80, clk cycles from CONVST rising edge to conversion done (1.6 us at 50 MHz).
- SYNC_STAGES, 2, synchronizer depth on spi_scl, spi_sdi and convst (minimum 2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- spi_scl  in  1  SPI clock from master, idle low, mode 0
- spi_sdi  in  1  MOSI, config bits, MSB first
- convst  in  1  conversion start / frame select (low = read window)
- spi_sdo  out  1  MISO, result bits, MSB first
- wr_en  in  1  load channel value
- wr_ch  in  2  channel index for load
- wr_data  in  12  channel value
- busy  out  1  conversion in progress
- cfg_valid  out  1  one-clk pulse: new config accepted
- cfg_word  out  6  last accepted config {S/D,O/S,S1,S0,UNI,SLP}
- cfg_err  out  1  one-clk pulse: short or unsupported config
- frame_err  out  1  one-clk pulse: CONVST fell during conversion
- frames_done  out  16  count of completed 12-bit readouts, wraps

Behaviour:
- Clock, reset and sampling:
  - Single clock clk; reset_n is asynchronous, active-low.
  - All SPI inputs pass through SYNC_STAGES flops; edges are detected on the synchronized signals.
  - Master SCK half-period must be at least SYNC_STAGES+2 clk.
  - SDO update latency is SYNC_STAGES+1 clk after the SCK falling edge at the pin.
- Reset values:
  - spi_sdo=0, busy=0, all pulses 0, frames_done=0, channel values 0.
  - cfg_word=6'b100010, so the first readout returns ch0.
  - State returns to S_IDLE.
- Channel decode:
  - ch = {S0, O/S}; requires S/D=1 and S1=0.
  - Supported codes: 100010->ch0, 110010->ch1, 100110->ch2, 110110->ch3.
- State S_IDLE:
  - SCK ignored; sdo=0.
  - convst rise -> S_CONV.
  - No config is captured from this frame; cfg_word is kept.
- State S_CONV:
  - busy=1; counter runs 0..CONV_CYCLES-1.
  - At terminal count -> S_WAIT, busy=0.
  - convst fall before terminal count -> frame_err pulse, go to S_IDLE, sdo=0.
- State S_WAIT:
  - convst fall -> load shift_reg with value[ch of cfg_word], drive sdo=bit11, clear bit counters, go to S_SHIFT.
- State S_SHIFT:
  - On SCK rise: while rx_cnt<6, shift sdi into cfg_sr; rx_cnt saturates at 6.
  - On SCK fall: while tx_cnt<12, advance sdo to the next bit and increment tx_cnt.
  - Once 11 falls have occurred, sdo holds bit0. Further falls drive sdo=0.
  - When tx_cnt reaches 12, increment frames_done.
- Exit from S_SHIFT on convst rise:
  - If rx_cnt==6 and the decode is supported: cfg_word<=cfg_sr and cfg_valid pulse.
  - If rx_cnt<6 or the decode is unsupported: cfg_err pulse and cfg_word is kept.
  - In all cases -> S_CONV.
- Result pipeline:
  - The result in frame N uses the config captured in frame N-1.
  - The shift register is snapshotted at CONVST fall, so wr_en to that channel mid-frame does not alter the bits being shifted.
  - wr_en writes value[wr_ch]<=wr_data in any state, 1-clk latency.
- Simultaneous events:
  - A convst edge and an SCK edge in the same cycle: the convst edge wins and the SCK edge is ignored.
- Reset asserted mid-frame: immediate return to reset values.

Optional Feature:
- Macro: ADC_RESP_AUTOINC_EN.
- Defined:
  - On each completed 12-bit readout, value[ch] increments by 1 and wraps 12'hFFF->12'h000.
  - A same-cycle wr_en to that channel takes priority over the increment.
- Undefined: channel values change only via wr_en.

Decomposition:
- Shared package spi_adc_pkg holds:
  - state enum (S_IDLE, S_CONV, S_WAIT, S_SHIFT);
  - CFG_W=6, DATA_W=12;
  - the four channel config constants;
  - the decode function cfg_to_ch.
- One sub-module, spi_sync_edge: SYNC_STAGES synchronizer plus rise/fall pulse outputs, instanced three times.

Test Plan:
- Reset, load ch0=12'hA5C, pulse convst, read 12 bits with SDI=100010 -> SDO 101001011100, frames_done=1, cfg_valid pulse, cfg_word=100010.
- Load ch2=12'h123; frame A sends 100110; frame B reads -> SDO 12'h123, proving the one-frame config pipeline.
- Drop convst 20 clk after rise with CONV_CYCLES=80 -> frame_err pulse, sdo=0, state S_IDLE, next normal frame works.
- Send only 4 SCK rises, then raise convst -> cfg_err pulse, cfg_word unchanged.
- Send unsupported config 000010 -> cfg_err pulse, cfg_word unchanged.
- wr_en ch1=12'hFFF mid-readout of ch1 (old 12'h010) -> SDO shows 12'h010; next ch1 frame shows 12'hFFF.
- With ADC_RESP_AUTOINC_EN, ch3=12'hFFF, two readouts -> 12'hFFF then 12'h000.
- Without ADC_RESP_AUTOINC_EN, same sequence -> 12'hFFF twice.
